// File: rtl/ddr3_sniffer_pkg.sv
// Shared definitions for the DDR3 sniffer datapath: bus widths, command and
// slave encodings, and the read-return beat tracking states.
package ddr3_sniffer_pkg;

  localparam int unsigned DATA_W = 288;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned ADDR_W = 28;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam logic SLV_APP   = 1'b0;
  localparam logic SLV_SNIFF = 1'b1;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } beat_state_t;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// 1-bit wide synchronous FIFO holding the slave id of each read in flight.
// The caller must not push when full (unless popping) nor pop when empty.
module ddr3_tag_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ddr3_rd_return_router.sv
// Routes DDR3 read-return beats to the slave that issued the read, using a
// tag FIFO filled at command accept time, and flags protocol errors.
module ddr3_rd_return_router #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = ddr3_sniffer_pkg::DATA_W
) (
  input  logic                   ddr3_clk,
  input  logic                   ddr3_rst_n,
  input  logic                   cmd_accept,
  input  logic                   cmd_is_read,
  input  logic                   cmd_slave,
  output logic                   tag_full,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   rd_data_valid,
  input  logic                   rd_data_end,
  output logic [DATA_W-1:0]      slave0_rd_data,
  output logic                   slave0_rd_data_valid,
  output logic                   slave0_rd_data_end,
  output logic [DATA_W-1:0]      slave1_rd_data,
  output logic                   slave1_rd_data_valid,
  output logic                   slave1_rd_data_end,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [2:0]             err_flags
);

  import ddr3_sniffer_pkg::*;

  logic        push_req;
  logic        push;
  logic        pop;
  logic        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [DATA_W-1:0] data_q;
  beat_state_t state;

  assign push_req = cmd_accept & cmd_is_read;
  assign pop      = rd_data_valid & rd_data_end & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~fifo_full | pop);

  ddr3_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk   (ddr3_clk),
    .rst_n (ddr3_rst_n),
    .push  (push),
    .din   (cmd_slave),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  assign tag_full = fifo_full;

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3_rst_n) begin
      state                <= BEAT0;
      err_flags            <= '0;
      data_q               <= '0;
      slave0_rd_data_valid <= 1'b0;
      slave0_rd_data_end   <= 1'b0;
      slave1_rd_data_valid <= 1'b0;
      slave1_rd_data_end   <= 1'b0;
    end else begin
      data_q               <= rd_data;
      slave0_rd_data_valid <= rd_data_valid & ~fifo_empty & (head == SLV_APP);
      slave0_rd_data_end   <= rd_data_valid & rd_data_end & ~fifo_empty & (head == SLV_APP);
      slave1_rd_data_valid <= rd_data_valid & ~fifo_empty & (head == SLV_SNIFF);
      slave1_rd_data_end   <= rd_data_valid & rd_data_end & ~fifo_empty & (head == SLV_SNIFF);

      if (push_req && fifo_full && !pop) err_flags[0] <= 1'b1;
      if (rd_data_valid && fifo_empty)   err_flags[1] <= 1'b1;

      if (rd_data_valid) begin
        case (state)
          BEAT0: begin
            if (rd_data_end) err_flags[2] <= 1'b1;
            else             state        <= BEAT1;
          end
          BEAT1: begin
            if (rd_data_end) state        <= BEAT0;
            else             err_flags[2] <= 1'b1;
          end
          default: state <= BEAT0;
        endcase
      end
    end
  end

  assign slave0_rd_data = data_q;
  assign slave1_rd_data = data_q;

endmodule

// File: tb/tb_ddr3_rd_return_router.sv
// Bench for ddr3_rd_return_router: directed cases plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_ddr3_rd_return_router;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 288;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_accept, cmd_is_read, cmd_slave;
  logic              tag_full;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid, rd_data_end;
  logic [DATA_W-1:0] slave0_rd_data, slave1_rd_data;
  logic              slave0_rd_data_valid, slave0_rd_data_end;
  logic              slave1_rd_data_valid, slave1_rd_data_end;
  logic [CW-1:0]     outstanding;
  logic [2:0]        err_flags;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                q[$];
  logic [2:0]        m_err;
  bit                m_in_burst;
  logic [DATA_W-1:0] e_data;
  bit                e_v0, e_e0, e_v1, e_e1;

  ddr3_rd_return_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .ddr3_clk             (clk),
    .ddr3_rst_n           (rst_n),
    .cmd_accept           (cmd_accept),
    .cmd_is_read          (cmd_is_read),
    .cmd_slave            (cmd_slave),
    .tag_full             (tag_full),
    .rd_data              (rd_data),
    .rd_data_valid        (rd_data_valid),
    .rd_data_end          (rd_data_end),
    .slave0_rd_data       (slave0_rd_data),
    .slave0_rd_data_valid (slave0_rd_data_valid),
    .slave0_rd_data_end   (slave0_rd_data_end),
    .slave1_rd_data       (slave1_rd_data),
    .slave1_rd_data_valid (slave1_rd_data_valid),
    .slave1_rd_data_end   (slave1_rd_data_end),
    .outstanding          (outstanding),
    .err_flags            (err_flags)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int unsigned i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input bit acc, input bit rd, input bit slv,
                       input bit vld, input bit en);
    cmd_accept    = acc;
    cmd_is_read   = rd;
    cmd_slave     = slv;
    rd_data_valid = vld;
    rd_data_end   = en;
    rd_data       = rand_data();
  endtask

  // Advance one clock: predict from the applied inputs, then compare.
  task automatic tick();
    bit have, pop_m, push_req;
    int head;
    if (!rst_n) begin
      q.delete();
      m_err      = '0;
      m_in_burst = 0;
      e_data     = '0;
      {e_v0, e_e0, e_v1, e_e1} = '0;
    end else begin
      have     = (q.size() > 0);
      head     = have ? q[0] : -1;
      push_req = cmd_accept && cmd_is_read;
      pop_m    = rd_data_valid && rd_data_end && have;
      e_data   = rd_data;
      e_v0     = rd_data_valid && head == 0;
      e_e0     = rd_data_valid && rd_data_end && head == 0;
      e_v1     = rd_data_valid && head == 1;
      e_e1     = rd_data_valid && rd_data_end && head == 1;
      if (push_req && q.size() == DEPTH && !pop_m) m_err[0] = 1'b1;
      if (rd_data_valid && !have) m_err[1] = 1'b1;
      // A beat whose end flag disagrees with being mid-burst is a framing error.
      if (rd_data_valid && (rd_data_end != m_in_burst)) m_err[2] = 1'b1;
      if (rd_data_valid) m_in_burst = !rd_data_end;
      if (pop_m) void'(q.pop_front());
      if (push_req && (q.size() < DEPTH || pop_m)) q.push_back(int'(cmd_slave));
    end
    @(posedge clk);
    #1;
    check_val("data0", slave0_rd_data, e_data);
    check_val("data1", slave1_rd_data, e_data);
    check_val("v0", DATA_W'(slave0_rd_data_valid), DATA_W'(e_v0));
    check_val("e0", DATA_W'(slave0_rd_data_end), DATA_W'(e_e0));
    check_val("v1", DATA_W'(slave1_rd_data_valid), DATA_W'(e_v1));
    check_val("e1", DATA_W'(slave1_rd_data_end), DATA_W'(e_e1));
    check_val("full", DATA_W'(tag_full), DATA_W'(q.size() == DEPTH));
    check_val("outst", DATA_W'(outstanding), DATA_W'(q.size()));
    check_val("err", DATA_W'(err_flags), DATA_W'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int tags[4] = '{0, 1, 1, 0};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Reset state
    do_reset();
    check_val("rst_outst", DATA_W'(outstanding), '0);
    check_val("rst_err", DATA_W'(err_flags), '0);
    check_val("rst_data", slave0_rd_data, '0);

    // routing
    foreach (tags[i]) begin
      drive(1, 1, tags[i][0], 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check_val("rt_outst4", DATA_W'(outstanding), DATA_W'(4));
    for (int b = 0; b < 4; b++) begin
      drive(0, 0, 0, 1, 0);
      tick();
      check_val("rt_b1_v0", DATA_W'(slave0_rd_data_valid), DATA_W'(b == 0 || b == 3));
      check_val("rt_b1_v1", DATA_W'(slave1_rd_data_valid), DATA_W'(b == 1 || b == 2));
      drive(0, 0, 0, 1, 1);
      tick();
      check_val("rt_b2_e0", DATA_W'(slave0_rd_data_end), DATA_W'(b == 0 || b == 3));
      check_val("rt_b2_e1", DATA_W'(slave1_rd_data_end), DATA_W'(b == 1 || b == 2));
      check_val("rt_outst", DATA_W'(outstanding), DATA_W'(3 - b));
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check_val("rt_err", DATA_W'(err_flags), '0);

    // overflow
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, i[0], 0, 0);
      tick();
      if (i == 15) check_val("ov_full16", DATA_W'(tag_full), DATA_W'(1));
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check_val("ov_err", DATA_W'(err_flags), DATA_W'(3'b001));
    check_val("ov_outst", DATA_W'(outstanding), DATA_W'(16));

    // full simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 1, 0, 0);
      tick();
    end
    check_val("fs_full", DATA_W'(tag_full), DATA_W'(1));
    drive(0, 0, 0, 1, 0);
    tick();
    drive(1, 1, 0, 1, 1);
    tick();
    check_val("fs_outst", DATA_W'(outstanding), DATA_W'(16));
    check_val("fs_err", DATA_W'(err_flags), '0);
    check_val("fs_v1", DATA_W'(slave1_rd_data_valid), DATA_W'(1));

    // orphan
    do_reset();
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    check_val("or_err", DATA_W'(err_flags), DATA_W'(3'b010));
    check_val("or_outst", DATA_W'(outstanding), '0);

    // framing: single-beat burst
    do_reset();
    drive(1, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    check_val("fr_v1", DATA_W'(slave1_rd_data_valid), DATA_W'(1));
    check_val("fr_e1", DATA_W'(slave1_rd_data_end), DATA_W'(1));
    check_val("fr_err", DATA_W'(err_flags), DATA_W'(3'b100));
    check_val("fr_outst", DATA_W'(outstanding), '0);
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    check_val("fr_beat0_again", DATA_W'(err_flags), DATA_W'(3'b100));

    // reset mid-burst
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i[0], 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    check_val("rm_outst", DATA_W'(outstanding), '0);
    check_val("rm_v0", DATA_W'(slave0_rd_data_valid), '0);
    check_val("rm_full", DATA_W'(tag_full), '0);
    check_val("rm_data", slave1_rd_data, '0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    check_val("rm_orphan", DATA_W'(err_flags[1]), DATA_W'(1));
    check_val("rm_v1", DATA_W'(slave1_rd_data_valid), '0);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit vld, en;
      rst_n = ($urandom_range(0, 149) != 0);
      vld   = ($urandom_range(0, 1) == 1);
      en    = ($urandom_range(0, 9) == 0) ? bit'($urandom_range(0, 1)) : m_in_burst;
      drive(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 1)), vld, en);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_rd_return_router.md
DDR3_RD_RETURN_ROUTER -- requirements
Module: ddr3_rd_return_router

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the read-tag FIFO depth (power of two, 4..64).
REQ-002 The block SHALL have parameter DATA_W, default 288, meaning the DDR3 read-data width.
REQ-003 Port ddr3_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port ddr3_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port cmd_accept, input, 1 bit: the controller accepted a command this cycle (master en and rdy both high).
REQ-006 Port cmd_is_read, input, 1 bit: the accepted command is a read (cmd 3'b001).
REQ-007 Port cmd_slave, input, 1 bit: arbiter slave id of the accepted command (0 = app FIFO, 1 = sniffer).
REQ-008 Port tag_full, output, 1 bit: the tag FIFO is full; the arbiter SHALL NOT grant reads while it is high.
REQ-009 Ports rd_data (input, DATA_W), rd_data_valid (input, 1) and rd_data_end (input, 1): the controller read-return bus.
REQ-010 Ports slaveN_rd_data (output, DATA_W), slaveN_rd_data_valid (output, 1) and slaveN_rd_data_end (output, 1), for N = 0 and 1: the per-slave return buses.
REQ-011 Port outstanding, output, clog2(DEPTH)+1 bits: number of reads in flight.
REQ-012 Port err_flags, output, 3 bits, sticky: bit0 overflow, bit1 orphan data, bit2 burst framing.

Function
REQ-013 A tag SHALL be pushed when cmd_accept, cmd_is_read and not tag_full are all high; the pushed value is cmd_slave.
REQ-014 If a push is requested while tag_full is high, the block SHALL drop the push and set err_flags[0].
REQ-015 A tag SHALL be popped on the cycle in which rd_data_valid and rd_data_end are both high and the FIFO is not empty.
REQ-016 A simultaneous push and pop SHALL leave outstanding unchanged.
REQ-017 A push and a pop on the same cycle SHALL both succeed when the FIFO is full.
REQ-018 The head tag SHALL select the destination slave.
REQ-019 rd_data SHALL be registered once and fanned out to both slaveN_rd_data.
REQ-020 Only the selected slave's valid and end outputs SHALL be asserted, and they SHALL be registered copies of rd_data_valid and rd_data_end; latency is exactly 1 cycle.
REQ-021 Read data arriving with an empty FIFO SHALL assert no slave valid, SHALL set err_flags[1], and SHALL NOT move the pointers.
REQ-022 A beat FSM SHALL track burst framing with states BEAT0 and BEAT1:
  - BEAT0 with valid and not end -> BEAT1.
  - BEAT1 with valid and end -> BEAT0.
  - BEAT0 with valid and end -> set err_flags[2], pop the tag, stay in BEAT0.
  - BEAT1 with valid and not end -> set err_flags[2], stay in BEAT1, no pop.
REQ-023 Non-valid cycles SHALL NOT change the FSM state.
REQ-024 tag_full SHALL be the registered count == DEPTH.
REQ-025 outstanding SHALL equal the count register.
REQ-026 The pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While ddr3_rst_n is low at a clock edge, the block SHALL clear the count and both pointers, set the FSM to BEAT0, and clear err_flags.
REQ-028 During reset, all slaveN valid and end outputs SHALL be 0, slaveN_rd_data SHALL be 0, tag_full SHALL be 0 and outstanding SHALL be 0.
REQ-029 On a reset mid-burst, the block SHALL discard in-flight tags; beats arriving after reset release SHALL be treated as orphans.
REQ-030 err_flags SHALL clear only on reset.

Structure
REQ-031 A shared package ddr3_sniffer_pkg SHALL hold the following:
  - DATA_W, the mask width and the address width.
  - Command encodings CMD_WRITE = 3'b000 and CMD_READ = 3'b001.
  - Slave ids SLV_APP = 0 and SLV_SNIFF = 1.
  - The beat-FSM state enum.
REQ-032 The tag storage SHALL be one sub-module, ddr3_tag_fifo: a synchronous FIFO, 1 bit wide and DEPTH deep, with push/pop/full/empty/count ports.

Verification
REQ-033 Bench case "routing": after reset, issue reads tagged 0, 1, 1, 0 and return four 2-beat bursts -> slave0 receives bursts 1 and 4, slave1 receives bursts 2 and 3, each 1 cycle after input, outstanding steps 4->0.
REQ-034 Bench case "overflow": with DEPTH=16, issue 17 reads with no returns -> tag_full high after the 16th, 17th push dropped, err_flags = 3'b001, outstanding = 16.
REQ-035 Bench case "full simultaneous": with the FIFO full, push and pop on the same cycle -> outstanding stays 16, no overflow error.
REQ-036 Bench case "orphan": return one burst with no reads outstanding -> no slave valid asserted, err_flags[1] = 1, outstanding = 0.
REQ-037 Bench case "framing": send a single-beat burst with end on the first beat -> err_flags[2] = 1, the tag is popped and routed, the FSM returns to BEAT0.
REQ-038 Bench case "reset mid-burst": with 3 outstanding, assert ddr3_rst_n low for 1 cycle between beats -> all outputs 0, outstanding = 0, the following beats are flagged as orphans.
